// File: rtl/w21_col_reader.sv
// Sequential reader / MAC engine for the W21 first-column weight ROM.
// Walks addresses 0..DEPTH-1 once per pass and accumulates x_in * w_in into one signed result.
module w21_col_reader #(
  parameter int DEPTH  = 300,
  parameter int ADRS_W = 9,
  parameter int W_W    = 21,
  parameter int X_W    = 16,
  parameter int ACC_W  = 46
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [X_W-1:0]    x_in,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [ADRS_W-1:0] adrs_clm,
  input  logic [W_W-1:0]    w_in,
  output logic [ACC_W-1:0]  result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int P_W = X_W + W_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic                    accept;
  logic                    last_beat;
  logic signed [P_W-1:0]   prod;
  logic        [ACC_W-1:0] acc;
  logic        [ACC_W-1:0] acc_sum;

  // Both operands are two's complement; the full-width product is then sign-extended.
  assign prod      = $signed(x_in) * $signed(w_in);
  assign acc_sum   = acc + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  assign last_beat = (adrs_clm == ADRS_W'(DEPTH-1));
  assign accept    = x_valid && (state == RUN);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    x_ready   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        x_ready = 1'b1;
        busy    = 1'b1;
        if (accept && last_beat) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      adrs_clm <= '0;
      result   <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc      <= '0;
        adrs_clm <= '0;
      end else if (accept) begin
        acc <= acc_sum;
        if (last_beat) begin
          // Address returns to 0 so the ROM never sees the unpopulated range.
          result   <= acc_sum;
          adrs_clm <= '0;
        end else begin
          adrs_clm <= adrs_clm + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_w21_col_reader.sv
// Self-checking bench for w21_col_reader: table-driven single-hot/extreme passes,
// randomized backpressure passes against a dot-product model, and reset/protocol sequences.
module tb_w21_col_reader;

  localparam int DEPTH = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x_in;
  logic        x_valid;
  logic        x_ready;
  logic [8:0]  adrs_clm;
  logic [20:0] w_in;
  logic [45:0] result;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic signed [20:0] rom  [DEPTH];
  logic signed [15:0] xbuf [DEPTH];

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  typedef struct {
    string              name;
    int                 hot;
    logic signed [15:0] val;
    bit                 fill;
    longint             exp;
    bit                 from_sum;
  } vec_t;

  vec_t vecs [5];

  w21_col_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .adrs_clm  (adrs_clm),
    .w_in      (w_in),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ROM stand-in; out-of-range addresses read as zero.
  assign w_in = (adrs_clm < 9'(DEPTH)) ? rom[adrs_clm] : 21'h0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint res_s();
    return longint'($signed(result));
  endfunction

  function automatic longint golden();
    longint s = 0;
    for (int i = 0; i < DEPTH; i++) s += longint'(xbuf[i]) * longint'(rom[i]);
    return s;
  endfunction

  function automatic longint rom_sum();
    longint s = 0;
    for (int i = 0; i < DEPTH; i++) s += longint'(rom[i]);
    return s;
  endfunction

  task automatic do_pass(input string name, input longint exp, input int stall_pct,
                         input int ready_delay, input bit poke_start, input bit timing_chk);
    longint t_start, held;
    int     beat, guard, addr_err, ov_err, stab_err;
    beat = 0; guard = 0; addr_err = 0; ov_err = 0; stab_err = 0;
    @(negedge clk);
    check({name, " idle_before"}, {x_ready, busy, out_valid}, 0);
    start   = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    check({name, " run_flags"}, {x_ready, busy, out_valid}, 3'b110);
    check({name, " addr_start"}, adrs_clm, 0);
    while (beat < DEPTH && guard < 4000) begin
      if (adrs_clm !== 9'(beat)) addr_err++;
      if (out_valid !== 1'b0 || x_ready !== 1'b1) ov_err++;
      x_valid = ($urandom_range(99) >= 32'(stall_pct));
      x_in    = xbuf[beat];
      start   = poke_start && ($urandom_range(7) == 0);
      @(negedge clk);
      if (x_valid) beat++;
      guard++;
    end
    x_valid = 1'b0;
    start   = 1'b0;
    check({name, " beats"}, beat, DEPTH);
    check({name, " addr_track"}, addr_err, 0);
    check({name, " run_outputs"}, ov_err, 0);
    check({name, " done_flags"}, {x_ready, busy, out_valid}, 3'b011);
    check({name, " addr_wrap"}, adrs_clm, 0);
    check({name, " result"}, res_s(), exp);
    if (timing_chk) check({name, " latency"}, cyc - t_start, 301);
    held = res_s();
    repeat (ready_delay) begin
      start = poke_start;
      @(negedge clk);
      if (res_s() !== held || out_valid !== 1'b1) stab_err++;
    end
    check({name, " hold_stable"}, stab_err, 0);
    out_ready = 1'b1;
    start     = poke_start;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check({name, " back_idle"}, {x_ready, busy, out_valid}, 0);
    @(negedge clk);
    check({name, " start_not_queued"}, {x_ready, busy, out_valid}, 0);
    check({name, " result_kept"}, res_s(), exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; x_in = '0; x_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 21'($urandom);
    rom[0]   = -21'sd181;
    rom[1]   = 21'sd278;
    rom[253] = 21'sd2232;

    vecs[0] = '{"hot0",   0,   16'sd1,     1'b0, -64'sd181,      1'b0};
    vecs[1] = '{"hot1",   1,   16'sd1,     1'b0, 64'sd278,       1'b0};
    vecs[2] = '{"hot253", 253, 16'sh8000,  1'b0, -64'sd73138176, 1'b0};
    vecs[3] = '{"ext_neg", 0,  16'sh8000,  1'b1, 64'sd0,         1'b1};
    vecs[4] = '{"ext_pos", 0,  16'sh7FFF,  1'b1, 64'sd0,         1'b1};

    repeat (2) @(negedge clk);
    check("reset_flags", {x_ready, busy, out_valid}, 0);
    check("reset_addr", adrs_clm, 0);
    check("reset_result", res_s(), 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      longint exp;
      for (int i = 0; i < DEPTH; i++) xbuf[i] = vecs[k].fill ? vecs[k].val : 16'sd0;
      if (!vecs[k].fill) xbuf[vecs[k].hot] = vecs[k].val;
      exp = vecs[k].from_sum ? longint'(vecs[k].val) * rom_sum() : vecs[k].exp;
      do_pass(vecs[k].name, exp, 0, 0, 1'b0, 1'b1);
    end

    // Random streams with stalls, late out_ready and stray start pulses, back to back.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) xbuf[i] = 16'($urandom);
      do_pass($sformatf("rand%0d", p), golden(), 30, 10, 1'b1, 1'b0);
    end

    // Abort mid-pass: everything, including the held result, returns to reset values.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    x_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      x_in = 16'($urandom);
      @(negedge clk);
    end
    check("mid_addr_150", adrs_clm, 150);
    rst = 1'b1;
    #1;
    check("rst_flags", {x_ready, busy, out_valid}, 0);
    check("rst_addr", adrs_clm, 0);
    check("rst_result", res_s(), 0);
    @(negedge clk);
    rst     = 1'b0;
    x_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) xbuf[i] = 16'sd0;
    do_pass("zeros_after_rst", 0, 0, 2, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/w21_col_reader.md
# w21_col_reader

Sequential reader and multiply-accumulate engine for the W21 first-column weight ROM (`w21_rom_c1`). It walks the ROM address space, consuming one activation per weight. It multiplies each activation by the signed weight returned for the current address and accumulates the 300 products into one signed dot-product result. The block sits between the activation stream from the previous layer and the W21 output stage, and it is the only driver of `adrs_clm`.

## Interface
- `DEPTH`, 300, number of weights per column; valid addresses are 0..299.
- `ADRS_W`, 9, address width.
- `W_W`, 21, weight width, signed two's complement.
- `X_W`, 16, activation width, signed two's complement.
- `ACC_W`, 46, accumulator/result width; equals `W_W + X_W + ADRS_W`, so no overflow is possible.

Ports (clock and reset first):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to begin a column pass; honoured only in IDLE.
- `x_in` input X_W: activation data.
- `x_valid` input 1: `x_in` is valid.
- `x_ready` output 1: block can accept an activation.
- `adrs_clm` output ADRS_W: registered ROM address.
- `w_in` input W_W: combinational ROM output for `adrs_clm`.
- `result` output ACC_W: signed dot product, held stable while `out_valid` is high.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: downstream accepts `result`.
- `busy` output 1: high in RUN and DONE.

## Operation
States:
- **IDLE**
  - `x_ready`=0, `out_valid`=0, `busy`=0.
  - On `start`: clear the accumulator, set `adrs_clm`=0, go to RUN.
- **RUN**
  - `x_ready`=1, `busy`=1.
  - A beat is accepted when `x_valid && x_ready`.
  - On each accepted beat, `acc` ← `acc` + sext(`x_in` × `w_in`). The product is a full signed `X_W+W_W` = 37-bit value, sign-extended to `ACC_W`.
  - If `adrs_clm` < `DEPTH-1`: `adrs_clm` increments and the state stays RUN.
  - If `adrs_clm` == `DEPTH-1`: `result` ← final sum including this product, `adrs_clm` ← 0, go to DONE.
  - When `x_valid` is low, all state holds (stall). There is no bubble penalty.
- **DONE**
  - `out_valid`=1, `x_ready`=0, `busy`=1.
  - `result` is frozen.
  - On `out_ready`: go to IDLE. `out_valid` drops the next cycle.

Boundary rules:
- `start` in RUN or DONE is ignored; it does not restart the pass and is not queued.
- `start` and `out_ready` in the same DONE cycle: go to IDLE only; `start` is ignored.
- Address wrap: `adrs_clm` never exceeds `DEPTH-1`. It returns to 0 on completion, so the ROM is never presented with unpopulated addresses 300..511.
- Multiplication is signed × signed. Neither operand is treated as unsigned.
- `rst` asserted at any time, including mid-pass or in DONE, aborts immediately. The partial accumulation is discarded.
- Reset values:
  - state = IDLE
  - `adrs_clm` = 0
  - accumulator = 0
  - `result` = 0
  - `x_ready` = 0
  - `out_valid` = 0
  - `busy` = 0

## Timing
- `start` sampled at edge N: RUN and `x_ready`=1 from cycle N+1, with `adrs_clm`=0.
- The ROM is combinational. `w_in` corresponding to `adrs_clm` is valid in the same cycle and is sampled with `x_in` at the accepting edge.
- The address advances on the edge that accepts a beat, so the next weight is present in the following cycle.
- With `x_valid` held high, a pass takes exactly `DEPTH` = 300 accept cycles.
- `out_valid` rises the cycle after the 300th accept: start-to-`out_valid` is 301 cycles minimum.
- `result` and `out_valid` are registered outputs; there is no combinational path from `x_in` or `w_in` to `result`.
- Throughput: one pass per 302 cycles minimum (start, 300 beats, one DONE cycle with `out_ready`=1).

## Test plan
- **Single-hot, address 0:** `x_valid` always high; `x_in`=1 at beat 0 and 0 at all other beats, with the real `w21_rom_c1` attached.
  - `result` = -181.
  - `out_valid` rises 301 cycles after `start`.
- **Single-hot, addresses 1 and 0x0FD:**
  - `x_in`=1 at beat 1 only → `result` = 278.
  - `x_in`=-32768 at beat 253 (address 0x0FD) only → `result` = -73138176.
- **Random stream with backpressure:** random signed activations; `x_valid` de-asserted randomly (~30%); `out_ready` held low 10 cycles after `out_valid`.
  - `result` matches the golden signed dot product.
  - `result` is stable while `out_valid` is high.
  - `adrs_clm` only advances on accepted beats.
- **Protocol corner cases:**
  - `start` pulses during RUN and during DONE → ignored.
  - Address sweeps 0..299 exactly once per pass, then returns to 0.
  - Back-to-back passes: the second `result` is independent of the first, because the accumulator is cleared.
- **Reset mid-pass:** assert `rst` at beat 150.
  - All outputs return to reset values immediately.
  - A new pass with all `x_in`=0 yields `result` = 0.
- **Extremes:** all `x_in`=-32768 for 300 beats.
  - `result` = -32768 × (sum of all 300 weights), with no wrap.
  - Bench also checks all `x_in`=32767.
